// File: rtl/led_sequencer.sv
// LED pattern engine: a prescaled step tick advances a binary, Gray, scan or down-count pattern.
// Latency: a tick or step sampled in cycle T shows on leds, with adv high, in cycle T+1.
// No backpressure: run pauses stepping, and step advances once per pulse while paused.
// Optional LED_SEQ_PWM_EN macro adds an 8-bit PWM brightness mask driven by duty.
module led_sequencer #(
    parameter int N_LEDS     = 6,
    parameter int DIV        = 6750000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic [1:0]        mode,
    input  logic [7:0]        duty,
    output logic [N_LEDS-1:0] leds,
    output logic              adv
);

    localparam int DW = $clog2(DIV);
    localparam int PW = $clog2(N_LEDS);
    localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0]     POS_LAST = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]     POS_ZERO = '0;
    localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);
    localparam logic              AL_BIT   = (ACTIVE_LOW != 0);

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_SCAN = 2'd2;
    localparam logic [1:0] MODE_DOWN = 2'd3;

    logic [DW-1:0]     div_cnt;
    logic [1:0]        mode_q;
    logic [N_LEDS-1:0] cnt;
    logic [PW-1:0]     pos;
    logic              dir;
    logic [PW-1:0]     pos_nxt;
    logic              dir_nxt;
    logic [N_LEDS-1:0] pattern;
    logic [N_LEDS-1:0] mask;
    logic              tick;
    logic              adv_ev;
    logic              mode_chg;
    logic              do_adv;

    // A mode change clears all stepping state and swallows any advance landing in the same cycle.
    assign tick     = run && (div_cnt == DIV_LAST);
    assign adv_ev   = tick || (!run && step);
    assign mode_chg = (mode != mode_q);
    assign do_adv   = adv_ev && !mode_chg;

    // Prescaler: counts while running, holds while paused so resume continues mid-period.
    always_ff @(posedge clk) begin
        if (rst || mode_chg) begin
            div_cnt <= '0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Mode history; reset loads the live mode so leaving reset does not look like a mode change.
    always_ff @(posedge clk) begin
        mode_q <= mode;
    end

    // Next scan position: the endpoint reached flips direction, so endpoints are shown only once.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (!dir) begin
            pos_nxt = pos + 1'b1;
            if (pos_nxt == POS_LAST) begin
                dir_nxt = 1'b1;
            end
        end else begin
            pos_nxt = pos - 1'b1;
            if (pos_nxt == POS_ZERO) begin
                dir_nxt = 1'b0;
            end
        end
    end

    // Pattern state update on each accepted advance, using the settled mode.
    always_ff @(posedge clk) begin
        if (rst || mode_chg) begin
            cnt <= '0;
            pos <= '0;
            dir <= 1'b0;
        end else if (do_adv) begin
            case (mode_q)
                MODE_BIN, MODE_GRAY: cnt <= cnt + 1'b1;
                MODE_DOWN:           cnt <= cnt - 1'b1;
                default: begin
                    pos <= pos_nxt;
                    dir <= dir_nxt;
                end
            endcase
        end
    end

    // Advance strobe aligned with the first cycle the new pattern is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            adv <= 1'b0;
        end else begin
            adv <= do_adv;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [7:0] pwm_cnt;
    logic [7:0] duty_q;

    // PWM carrier; duty is taken only at the end of a period so each period has a single duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
            duty_q  <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hff) begin
                duty_q <= duty;
            end
        end
    end

    assign mask = {N_LEDS{(pwm_cnt < duty_q)}};
`else
    logic unused_duty;

    assign unused_duty = ^duty;
    assign mask        = {N_LEDS{1'b1}};
`endif

    // Pattern decode from registered state only, so leds never glitch on input changes.
    always_comb begin
        pattern = cnt;
        case (mode_q)
            MODE_GRAY: pattern = cnt ^ (cnt >> 1);
            MODE_SCAN: pattern = LED_ONE << pos;
            default:   pattern = cnt;
        endcase
    end

    assign leds = (pattern & mask) ^ {N_LEDS{AL_BIT}};

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       step;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [3:0] leds;
    logic       adv;

    int n_checks = 0;
    int n_fail   = 0;
    int m_pc     = 0;
    int m_dq     = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .N_LEDS    (4),
        .DIV       (4),
        .ACTIVE_LOW(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .run (run),
        .step(step),
        .mode(mode),
        .duty(duty),
        .leds(leds),
        .adv (adv)
    );

    // Advance one clock; the PWM reference state follows the inputs sampled at this edge.
    task automatic cyc();
`ifdef LED_SEQ_PWM_EN
        if (rst) begin
            m_pc = 0;
            m_dq = 0;
        end else begin
            if (m_pc == 255) m_dq = duty;
            m_pc = (m_pc + 1) % 256;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_leds(input logic [3:0] pat);
`ifdef LED_SEQ_PWM_EN
        return (m_pc < m_dq) ? pat : 4'h0;
`else
        return pat;
`endif
    endfunction

    task automatic chk(input string tag, input logic [3:0] pat, input logic a);
        logic [3:0] e;
        e = exp_leds(pat);
        n_checks++;
        assert (leds === e) else begin
            n_fail++;
            $error("FAIL %s: leds=%h expected %h", tag, leds, e);
        end
        n_checks++;
        assert (adv === a) else begin
            n_fail++;
            $error("FAIL %s: adv=%b expected %b", tag, adv, a);
        end
    endtask

    // One free-running step with DIV=4: three quiet cycles, then the new pattern with adv.
    task automatic do_step(input string tag, input logic [3:0] prev, input logic [3:0] nxt);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk(tag, prev, 1'b0);
        end
        cyc();
        chk(tag, nxt, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gray_seq [6];
        logic [3:0] scan_seq [8];
        logic [3:0] prev;
        int         hi;
        bit         found;

        gray_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5};
        scan_seq = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2, 4'd4};
        hi       = 0;
        found    = 1'b0;

        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        mode = 2'd0;
        duty = 8'd255;
        cyc();
        cyc();
        chk("reset", 4'h0, 1'b0);

        // Binary up, free running, through the 15 -> 0 wrap.
        rst = 1'b0;
        run = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            do_step("bin_up", 4'((s - 1) % 16), 4'(s % 16));
        end

        // Gray up after a mode change clear.
        mode = 2'd1;
        cyc();
        chk("gray_clr", 4'h0, 1'b0);
        prev = 4'h0;
        for (int s = 0; s < 6; s++) begin
            do_step("gray", prev, gray_seq[s]);
            prev = gray_seq[s];
        end

        // Bounce scan; position 0 after clear shows as LED 0 lit.
        mode = 2'd2;
        cyc();
        chk("scan_clr", 4'h1, 1'b0);
        prev = 4'h1;
        for (int s = 0; s < 8; s++) begin
            do_step("scan", prev, scan_seq[s]);
            prev = scan_seq[s];
        end

        // Pause with the prescaler part-way (div_cnt=2), then hold for 20 cycles.
        mode = 2'd0;
        cyc();
        chk("pause_clr", 4'h0, 1'b0);
        cyc();
        chk("pause_pre", 4'h0, 1'b0);
        cyc();
        chk("pause_pre", 4'h0, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("frozen", 4'h0, 1'b0);
        end

        // Single steps: separated pulses, then back-to-back pulses.
        step = 1'b1; cyc(); chk("step1", 4'h1, 1'b1);
        step = 1'b0; cyc(); chk("step_gap", 4'h1, 1'b0);
        step = 1'b1; cyc(); chk("step2", 4'h2, 1'b1);
        step = 1'b0; cyc(); chk("step_gap", 4'h2, 1'b0);
        step = 1'b1; cyc(); chk("step3", 4'h3, 1'b1);
        cyc(); chk("step_b2b", 4'h4, 1'b1);
        cyc(); chk("step_b2b", 4'h5, 1'b1);
        step = 1'b0; cyc(); chk("step_idle", 4'h5, 1'b0);

        // Resume from held div_cnt=2 with step ignored; the next cycle is the tick cycle.
        run  = 1'b1;
        step = 1'b1;
        cyc();
        chk("run_step_ign", 4'h5, 1'b0);
        // Mode change in the tick cycle wins: pattern clears and no adv.
        step = 1'b0;
        mode = 2'd3;
        cyc();
        chk("mode_chg_tick", 4'h0, 1'b0);
        do_step("down_first", 4'h0, 4'hf);
        do_step("down", 4'hf, 4'he);

        // Pause mid-period and resume: tick lands exactly on the remaining count.
        cyc();
        chk("resume_pre", 4'he, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("resume_hold", 4'he, 1'b0);
        end
        run = 1'b1;
        cyc(); chk("resume", 4'he, 1'b0);
        cyc(); chk("resume", 4'he, 1'b0);
        cyc(); chk("resume_tick", 4'hd, 1'b1);

        // Reset asserted in a tick cycle overrides the advance.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pre_rst", 4'hd, 1'b0);
        end
        rst = 1'b1;
        cyc();
        chk("rst_mid", 4'h0, 1'b0);
        rst = 1'b0;
        do_step("post_rst", 4'h0, 4'hf);

`ifdef LED_SEQ_PWM_EN
        // Freeze pattern 15 and measure the lit fraction of one PWM period.
        run  = 1'b0;
        duty = 8'd64;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            cyc();
            chk("pwm_wait64", 4'hf, 1'b0);
            if (m_pc == 0 && m_dq == 64) found = 1'b1;
        end
        n_checks++;
        assert (found === 1'b1) else begin
            n_fail++;
            $error("FAIL pwm_load64: reference load seen=%b expected 1", found);
        end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (leds[0] === 1'b1) hi++;
            chk("pwm64", 4'hf, 1'b0);
            cyc();
        end
        n_checks++;
        assert (hi === 64) else begin
            n_fail++;
            $error("FAIL pwm64_count: lit=%0d expected 64", hi);
        end

        duty  = 8'd0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            cyc();
            if (m_pc == 0 && m_dq == 0) found = 1'b1;
        end
        n_checks++;
        assert (found === 1'b1) else begin
            n_fail++;
            $error("FAIL pwm_load0: reference load seen=%b expected 1", found);
        end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (leds !== 4'h0) hi++;
            cyc();
        end
        n_checks++;
        assert (hi === 0) else begin
            n_fail++;
            $error("FAIL pwm0_dark: lit cycles=%0d expected 0", hi);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
